mem_access_unit: RTL and testbench

//  Parametrised memory stage placed between EX and WB. Sequences loads and stores over a
//  req/ack data bus that may insert wait states. Builds byte-lane strobes and replicated store

---
 rtl/mem_access_unit.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory stage between EX and WB: runs loads/stores over a req/ack bus with wait states,
// builds strobes and replicated store data, aligns/extends load data and raises exceptions.
module mem_access_unit #(
  parameter int          XLEN       = 32,
  parameter logic [31:0] ADDR_LIMIT = 32'h6000_0000,
  parameter int          TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              in_we,
  input  logic              in_re,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_wen,
  input  logic [XLEN-1:0]   in_result,
  output logic              ms_to_ws_valid,
  input  logic              ws_allowin,
  output logic [4:0]        ws_rd,
  output logic              ws_rd_wen,
  output logic [XLEN-1:0]   ws_wdata,
  output logic [XLEN-1:0]   ws_pc,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [XLEN-1:0]   dbus_addr,
  output logic [XLEN-1:0]   dbus_wdata,
  output logic [XLEN/8-1:0] dbus_strb,
  input  logic              dbus_ack,
  input  logic [XLEN-1:0]   dbus_rdata,
  output logic              exc_valid,
  output logic [5:0]        exc_code,
  output logic [XLEN-1:0]   exc_tval
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = (XLEN == 64) ? 3 : 2;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [5:0] LD_MISAL = 6'b100100;
  localparam logic [5:0] LD_FAULT = 6'b100101;
  localparam logic [5:0] ST_MISAL = 6'b100110;
  localparam logic [5:0] ST_FAULT = 6'b100111;

  typedef enum logic [1:0] {IDLE, REQ, DONE, EXC} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt_p1;
  logic              store_p1;
  logic              uns_p1;
  logic [1:0]        size_p1;
  logic [OFF_W-1:0]  off_p1;
  logic [XLEN-1:0]   addr_p1;

  logic is_mem, size_bad, misal, oor, capture;

  function automatic logic [STRB_W-1:0] lane_strb(input logic [1:0] size,
                                                  input logic [OFF_W-1:0] off);
    logic [STRB_W-1:0] mask;
    case (size)
      2'b00:   mask = STRB_W'(1);
      2'b01:   mask = STRB_W'(3);
      2'b10:   mask = STRB_W'(15);
      default: mask = '1;
    endcase
    return mask << off;
  endfunction

  function automatic logic [XLEN-1:0] replicate(input logic [1:0] size,
                                                input logic [XLEN-1:0] data);
    logic [XLEN-1:0] r;
    case (size)
      2'b00:   r = {(XLEN/8){data[7:0]}};
      2'b01:   r = {(XLEN/16){data[15:0]}};
      2'b10:   r = {(XLEN/32){data[31:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0]  rdata,
                                                  input logic [1:0]       size,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic             uns);
    logic [XLEN-1:0]        sh;
    logic [XLEN-1:0]        zext;
    logic signed [XLEN-1:0] sext;
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic signed [31:0]     w;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    w  = sh[31:0];
    case (size)
      2'b00:   begin zext = XLEN'(sh[7:0]);  sext = XLEN'(b); end
      2'b01:   begin zext = XLEN'(sh[15:0]); sext = XLEN'(h); end
      2'b10:   begin zext = XLEN'(sh[31:0]); sext = XLEN'(w); end
      default: begin zext = sh;              sext = sh;       end
    endcase
    return uns ? zext : sext;
  endfunction

  assign is_mem   = in_we | in_re;
  assign size_bad = (in_size == 2'b11) && (XLEN == 32);
  assign oor      = in_addr > XLEN'(ADDR_LIMIT);

  always_comb begin
    case (in_size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = in_addr[0];
      2'b10:   misal = |in_addr[1:0];
      default: misal = |in_addr[2:0];
    endcase
  end

  assign ms_allowin     = (state == IDLE) || (((state == DONE) || (state == EXC)) && ws_allowin);
  assign ms_to_ws_valid = (state == DONE);
  // An exception parks the stage until the trap unit flushes it, so nothing is taken in EXC.
  assign capture        = es_to_ms_valid && ms_allowin && !flush && (state != EXC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt_p1     <= '0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      dbus_strb  <= '0;
      ws_rd      <= '0;
      ws_rd_wen  <= 1'b0;
      ws_wdata   <= '0;
      ws_pc      <= '0;
      exc_valid  <= 1'b0;
      exc_code   <= '0;
      exc_tval   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      dbus_req  <= 1'b0;
      dbus_we   <= 1'b0;
      dbus_strb <= '0;
      exc_valid <= 1'b0;
      ws_rd_wen <= 1'b0;
    end else if (capture) begin
      // capture -> p1: op fields registered, next state decided from the incoming op
      store_p1 <= in_we;
      uns_p1   <= in_unsigned;
      size_p1  <= in_size;
      off_p1   <= in_addr[OFF_W-1:0];
      addr_p1  <= in_addr;
      ws_rd    <= in_rd;
      ws_pc    <= in_pc;
      cnt_p1   <= CNT_W'(1);
      if (!is_mem) begin
        state     <= DONE;
        ws_wdata  <= in_result;
        ws_rd_wen <= in_rd_wen;
      end else if (size_bad || misal || oor) begin
        state     <= EXC;
        exc_valid <= 1'b1;
        exc_tval  <= in_addr;
        ws_rd_wen <= 1'b0;
        if (misal && !size_bad) exc_code <= in_we ? ST_MISAL : LD_MISAL;
        else                    exc_code <= in_we ? ST_FAULT : LD_FAULT;
      end else begin
        state      <= REQ;
        dbus_req   <= 1'b1;
        dbus_we    <= in_we;
        dbus_addr  <= in_addr & ~XLEN'(STRB_W - 1);
        dbus_wdata <= in_we ? replicate(in_size, in_wdata) : '0;
        dbus_strb  <= in_we ? lane_strb(in_size, in_addr[OFF_W-1:0]) : '0;
        ws_wdata   <= '0;
        ws_rd_wen  <= !in_we && in_rd_wen;
      end
    end else begin
      case (state)
        REQ: begin
          if (dbus_ack) begin
            state     <= DONE;
            dbus_req  <= 1'b0;
            dbus_we   <= 1'b0;
            dbus_strb <= '0;
            if (!store_p1) ws_wdata <= load_extend(dbus_rdata, size_p1, off_p1, uns_p1);
          end else if (cnt_p1 == CNT_W'(TIMEOUT)) begin
            state     <= EXC;
            dbus_req  <= 1'b0;
            dbus_we   <= 1'b0;
            dbus_strb <= '0;
            exc_valid <= 1'b1;
            exc_code  <= store_p1 ? ST_FAULT : LD_FAULT;
            exc_tval  <= addr_p1;
            ws_rd_wen <= 1'b0;
          end else begin
            cnt_p1 <= cnt_p1 + CNT_W'(1);
          end
        end
        DONE:    if (ws_allowin) state <= IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized ops
// compared against a byte-level reference model of the memory stage.
module tb_mem_access_unit;
  localparam int          XLEN    = 32;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] LIMIT   = 32'h6000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, es_to_ms_valid, ms_allowin;
  logic [31:0] in_addr, in_wdata, in_pc, in_result;
  logic        in_we, in_re, in_unsigned, in_rd_wen;
  logic [1:0]  in_size;
  logic [4:0]  in_rd;
  logic        ms_to_ws_valid, ws_allowin;
  logic [4:0]  ws_rd;
  logic        ws_rd_wen;
  logic [31:0] ws_wdata, ws_pc;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_strb;
  logic        exc_valid;
  logic [5:0]  exc_code;
  logic [31:0] exc_tval;

  int n_chk = 0;
  int n_err = 0;

  mem_access_unit #(.XLEN(XLEN), .ADDR_LIMIT(LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_pc(in_pc),
    .in_we(in_we), .in_re(in_re), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_result(in_result),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ws_rd(ws_rd), .ws_rd_wen(ws_rd_wen), .ws_wdata(ws_wdata), .ws_pc(ws_pc),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_strb(dbus_strb),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic int nbytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic logic [5:0] model_exc(input logic [31:0] a, input logic [1:0] s, input bit st);
    if (s == 2'b11)           return st ? 6'b100111 : 6'b100101;
    if (a % nbytes(s) != 0)   return st ? 6'b100110 : 6'b100100;
    if (a > LIMIT)            return st ? 6'b100111 : 6'b100101;
    return 6'b000000;
  endfunction

  function automatic logic [3:0] model_strb(input logic [31:0] a, input logic [1:0] s);
    int m;
    m = ((1 << nbytes(s)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nbytes(s)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] s, input bit uns);
    longint      v;
    logic [63:0] t;
    int          nb, off;
    nb  = nbytes(s);
    off = a % 4;
    v   = 0;
    for (int i = 0; i < nb; i++) v = v + (longint'(rd[8*(off+i) +: 8]) << (8*i));
    if (!uns && v >= (longint'(1) << (8*nb - 1))) v = v - (longint'(1) << (8*nb));
    t = v;
    return t[31:0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req"},    dbus_req, 0);
    check_val({tag, "_we"},     dbus_we, 0);
    check_val({tag, "_addr"},   dbus_addr, 0);
    check_val({tag, "_wdata"},  dbus_wdata, 0);
    check_val({tag, "_strb"},   dbus_strb, 0);
    check_val({tag, "_wsrd"},   {ws_rd, ws_rd_wen}, 0);
    check_val({tag, "_wsdata"}, ws_wdata, 0);
    check_val({tag, "_wspc"},   ws_pc, 0);
    check_val({tag, "_exc"},    {exc_valid, exc_code}, 0);
    check_val({tag, "_tval"},   exc_tval, 0);
    check_val({tag, "_valid"},  ms_to_ws_valid, 0);
    check_val({tag, "_allow"},  ms_allowin, 1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_val("flush_excclr", exc_valid, 0);
    check_val("flush_allow", ms_allowin, 1);
  endtask

  // Issue one op from IDLE, service the bus, check the outcome and return to IDLE.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input bit we, input bit re, input logic [1:0] s, input bit uns,
                        input logic [4:0] rd, input bit rdw, input logic [31:0] res,
                        input int waits, input bit give_ack, input logic [31:0] rdat,
                        input int hold);
    logic [31:0] pc;
    logic [5:0]  ec;
    bit          mem, done;
    int          reqs;
    pc  = $urandom;
    mem = we | re;
    ec  = mem ? model_exc(a, s, we) : 6'b0;
    in_addr = a; in_wdata = d; in_we = we; in_re = re; in_size = s; in_unsigned = uns;
    in_rd = rd; in_rd_wen = rdw; in_result = res; in_pc = pc;
    es_to_ms_valid = 1'b1;
    ws_allowin     = 1'b1;
    check_val({tag, "_allow_idle"}, ms_allowin, 1);
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    if (ec != 0) begin
      check_val({tag, "_exc_valid"}, exc_valid, 1);
      check_val({tag, "_exc_code"}, exc_code, ec);
      check_val({tag, "_exc_tval"}, exc_tval, a);
      check_val({tag, "_exc_noreq"}, dbus_req, 0);
      check_val({tag, "_exc_novalid"}, {ms_to_ws_valid, ws_rd_wen}, 0);
      repeat (2) @(posedge clk);
      #1;
      check_val({tag, "_exc_hold"}, exc_valid, 1);
      do_flush();
      return;
    end
    if (mem) begin
      reqs = 0;
      done = 0;
      for (int k = 0; k < TIMEOUT + 4 && !done; k++) begin
        if (dbus_req !== 1'b1) done = 1;
        else begin
          reqs++;
          if (k == 0 || k == waits) begin
            check_val({tag, "_addr"}, dbus_addr, a - (a % 4));
            check_val({tag, "_we"}, dbus_we, we);
            check_val({tag, "_strb"}, dbus_strb, we ? model_strb(a, s) : 4'b0);
            if (we) check_val({tag, "_wdata"}, dbus_wdata, model_wdata(d, s));
          end
          if (give_ack && k == waits) begin
            dbus_ack   = 1'b1;
            dbus_rdata = rdat;
          end
          @(posedge clk); #1;
          dbus_ack   = 1'b0;
          dbus_rdata = $urandom;
        end
      end
      check_val({tag, "_reqcycles"}, reqs, give_ack ? waits + 1 : TIMEOUT);
      if (!give_ack) begin
        check_val({tag, "_to_exc"}, {exc_valid, exc_code}, {1'b1, we ? 6'b100111 : 6'b100101});
        check_val({tag, "_to_tval"}, exc_tval, a);
        check_val({tag, "_to_novalid"}, ms_to_ws_valid, 0);
        do_flush();
        return;
      end
    end
    check_val({tag, "_valid"}, ms_to_ws_valid, 1);
    check_val({tag, "_rd"}, ws_rd, rd);
    check_val({tag, "_pc"}, ws_pc, pc);
    check_val({tag, "_rdwen"}, ws_rd_wen, we ? 1'b0 : rdw);
    if (!we) check_val({tag, "_wsdata"}, ws_wdata, mem ? model_load(rdat, a, s, uns) : res);
    ws_allowin = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_val({tag, "_hold"}, {ms_to_ws_valid, ms_allowin}, 2'b10);
    end
    ws_allowin = 1'b1;
    @(posedge clk); #1;
    check_val({tag, "_retire"}, {ms_to_ws_valid, ms_allowin}, 2'b01);
  endtask

  // Pass-through stream under random WB backpressure: every op appears once, in order.
  task automatic stream(input int n);
    logic [31:0] vals[$];
    logic [31:0] got[$];
    logic [31:0] pcs[$];
    int idx, cyc;
    idx = 0;
    cyc = 0;
    for (int i = 0; i < n; i++) vals.push_back($urandom);
    in_we = 1'b0;
    in_re = 1'b0;
    in_rd_wen = 1'b1;
    while (got.size() < n && cyc < 40 * n) begin
      es_to_ms_valid = (idx < n);
      if (idx < n) begin
        in_result = vals[idx];
        in_pc     = vals[idx] ^ 32'h5A5A_0F0F;
        in_rd     = idx[4:0];
      end
      ws_allowin = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ms_to_ws_valid && ws_allowin) begin
        got.push_back(ws_wdata);
        pcs.push_back(ws_pc);
      end
      if (es_to_ms_valid && ms_allowin) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("stream_count", got.size(), n);
    for (int i = 0; i < got.size(); i++) begin
      check_val("stream_order", got[i], vals[i]);
      check_val("stream_pc", pcs[i], vals[i] ^ 32'h5A5A_0F0F);
    end
  endtask

  task automatic random_ops(input int n);
    int          kind, r, nb, waits, hold;
    logic [1:0]  s;
    logic [31:0] a;
    bit          we, re, give_ack;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 2);
      s    = 2'($urandom_range(0, 2));
      nb   = nbytes(s);
      a    = $urandom_range(0, 32'h5FFF_FFFF);
      a    = a - (a % nb);
      r    = $urandom_range(0, 9);
      if (r == 0) a = LIMIT + nb * $urandom_range(1, 1000);
      else if (r == 1 && s != 0) a = a + 1;
      else if (r == 2) begin s = 2'b11; a = a - (a % 8); end
      else if (r == 3) a = LIMIT;
      we = (kind == 2);
      re = (kind == 1) || (kind == 2 && $urandom_range(0, 4) == 0);
      waits    = $urandom_range(0, 4);
      give_ack = ($urandom_range(0, 7) != 0);
      hold     = $urandom_range(0, 2);
      run_op("rnd", a, $urandom, we, re, s, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), $urandom, waits, give_ack, $urandom, hold);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
    in_addr = '0; in_wdata = '0; in_pc = '0; in_result = '0;
    in_we = 1'b0; in_re = 1'b0; in_size = 2'b00; in_unsigned = 1'b0;
    in_rd = '0; in_rd_wen = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    run_op("t1_sw", 32'h1000_0004, 32'hDEAD_BEEF, 1, 0, 2'b10, 0, 5'd3, 1, 0, 3, 1, 0, 1);
    run_op("t2_lb_s", 32'h2000_0003, 0, 0, 1, 2'b00, 0, 5'd7, 1, 0, 1, 1, 32'h8012_3456, 0);
    run_op("t2_lb_u", 32'h2000_0003, 0, 0, 1, 2'b00, 1, 5'd7, 1, 0, 0, 1, 32'h8012_3456, 0);
    run_op("t3_sh", 32'h1000_0002, 32'h0000_1234, 1, 0, 2'b01, 0, 5'd1, 1, 0, 0, 1, 0, 0);
    run_op("t3_sh_mis", 32'h1000_0001, 32'h0000_1234, 1, 0, 2'b01, 0, 5'd1, 1, 0, 0, 1, 0, 0);
    run_op("t4_lw_oor", 32'h6000_0004, 0, 0, 1, 2'b10, 0, 5'd2, 1, 0, 0, 1, 0, 0);
    run_op("t4_lw_edge", 32'h6000_0000, 0, 0, 1, 2'b10, 0, 5'd2, 1, 0, 2, 1, 32'hCAFE_F00D, 0);
    run_op("t4_lw_to", 32'h0000_0100, 0, 0, 1, 2'b10, 0, 5'd2, 1, 0, 0, 0, 0, 0);
    run_op("lh_neg", 32'h0000_0202, 0, 0, 1, 2'b01, 0, 5'd9, 1, 0, 2, 1, 32'h9ABC_0000, 2);
    run_op("ld_size3", 32'h0000_0008, 0, 0, 1, 2'b11, 0, 5'd9, 1, 0, 0, 1, 0, 0);
    run_op("pass", 32'h0, 0, 0, 0, 2'b10, 0, 5'd31, 1, 32'h1357_9BDF, 0, 1, 0, 2);

    stream(3);
    stream(20);

    // ack while idle must be ignored
    dbus_ack = 1'b1;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    check_val("idle_ack", {ms_to_ws_valid, dbus_req}, 2'b00);

    // flush together with an offered op: nothing captured
    in_addr = 32'h0000_0040; in_we = 1'b1; in_re = 1'b0; in_size = 2'b10;
    es_to_ms_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0; flush = 1'b0;
    check_val("flush_cap", {dbus_req, ms_to_ws_valid, exc_valid}, 3'b000);

    // flush during REQ with a coincident ack
    in_addr = 32'h0000_0080; in_we = 1'b0; in_re = 1'b1; in_size = 2'b10; in_rd_wen = 1'b1;
    es_to_ms_valid = 1'b1;
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    check_val("flush_req_up", dbus_req, 1);
    dbus_ack = 1'b1; dbus_rdata = 32'h1111_2222; flush = 1'b1;
    @(posedge clk); #1;
    dbus_ack = 1'b0; flush = 1'b0;
    check_val("flush_ack", {ms_to_ws_valid, dbus_req, ms_allowin}, 3'b001);
    repeat (3) @(posedge clk);
    #1;
    check_val("flush_ack_later", ms_to_ws_valid, 0);

    // reset in the middle of a store request
    in_addr = 32'h0000_00C4; in_wdata = 32'hA5A5_5A5A; in_we = 1'b1; in_re = 1'b0;
    in_size = 2'b10; in_pc = 32'h0000_4444; in_rd = 5'd4;
    es_to_ms_valid = 1'b1;
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    check_val("rst_req_up", dbus_req, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("rst_mid");

    random_ops(60);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
